seq_frame_sync_ctrl: RTL and testbench

//  Frame-sync controller around an overlapping serial pattern detector. Hunts a qualified bit stream for
//  a programmable sync word, confirms it at fixed frame spacing, declares lock, and flywheels through

---
 rtl/seq_frame_sync_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seq_frame_sync_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_sync_ctrl.sv
// Frame-sync controller: hunts a serial stream for a programmable sync word,
// verifies it at frame spacing, declares lock and flywheels through isolated misses.
module seq_frame_sync_ctrl #(
  parameter int unsigned      PAT_W       = 5,
  parameter int unsigned      CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(5'b11011),
  parameter logic [CNT_W-1:0] DEF_FLEN    = CNT_W'(16),
  parameter int unsigned      LOCK_CNT    = 3,
  parameter int unsigned      MISS_CNT    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_flen,
  output logic             match,
  output logic             locked,
  output logic             frame_start,
  output logic             lost,
  output logic [1:0]       sync_state,
  output logic [15:0]      match_count
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam int unsigned HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(MISS_CNT + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2,
    ST_FLY    = 2'd3
  } state_t;

  state_t             r_state;
  logic [PAT_W-2:0]   r_sr;
  logic [FILL_W-1:0]  r_fill;
  logic [CNT_W-1:0]   r_pos;
  logic [HIT_W-1:0]   r_hits;
  logic [MISS_W-1:0]  r_misses;
  logic [PAT_W-1:0]   r_pattern;
  logic [CNT_W-1:0]   r_flen;

  logic [PAT_W-1:0]   w_window;
  logic [CNT_W-1:0]   w_flen_eff;
  logic               w_hit;
  logic               w_ckpt;

  // Window includes the bit being accepted now, so a hit is seen on that bit.
  assign w_window   = {r_sr, in};
  assign w_flen_eff = (r_flen < CNT_W'(PAT_W)) ? CNT_W'(PAT_W) : r_flen;
  assign w_hit      = en && (r_fill >= FILL_W'(PAT_W - 1)) && (w_window == r_pattern);
  assign w_ckpt     = en && (r_pos == (w_flen_eff - CNT_W'(1)));
  assign sync_state = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_HUNT;
      r_sr        <= '0;
      r_fill      <= '0;
      r_pos       <= '0;
      r_hits      <= '0;
      r_misses    <= '0;
      r_pattern   <= DEF_PATTERN;
      r_flen      <= DEF_FLEN;
      match       <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      lost        <= 1'b0;
      match_count <= '0;
    end else begin
      match       <= 1'b0;
      frame_start <= 1'b0;
      lost        <= 1'b0;
      if (cfg_load) begin
        r_pattern   <= cfg_pattern;
        r_flen      <= cfg_flen;
        r_sr        <= '0;
        r_fill      <= '0;
        r_pos       <= '0;
        r_hits      <= '0;
        r_misses    <= '0;
        match_count <= '0;
        r_state     <= ST_HUNT;
        locked      <= 1'b0;
      end else if (en) begin
        r_sr  <= w_window[PAT_W-2:0];
        match <= w_hit;
        if (r_fill != FILL_W'(PAT_W)) r_fill <= r_fill + FILL_W'(1);
        if (w_hit && (match_count != 16'hFFFF)) match_count <= match_count + 16'd1;
        // Frame position only runs once a candidate sync has been seen.
        if (r_state == ST_HUNT || w_ckpt) r_pos <= '0;
        else                              r_pos <= r_pos + CNT_W'(1);

        case (r_state)
          ST_HUNT: begin
            if (w_hit) begin
              r_hits <= HIT_W'(1);
              if (LOCK_CNT <= 1) begin
                r_state     <= ST_LOCK;
                r_misses    <= '0;
                locked      <= 1'b1;
                frame_start <= 1'b1;
              end else begin
                r_state <= ST_VERIFY;
              end
            end
          end
          ST_VERIFY: begin
            if (w_ckpt) begin
              if (w_hit) begin
                r_hits <= r_hits + HIT_W'(1);
                if (r_hits == HIT_W'(LOCK_CNT - 1)) begin
                  r_state     <= ST_LOCK;
                  r_misses    <= '0;
                  locked      <= 1'b1;
                  frame_start <= 1'b1;
                end
              end else begin
                r_state <= ST_HUNT;
              end
            end
          end
          ST_LOCK: begin
            if (w_ckpt) begin
              if (w_hit) begin
                r_misses    <= '0;
                frame_start <= 1'b1;
              end else if (MISS_CNT <= 1) begin
                r_state <= ST_HUNT;
                locked  <= 1'b0;
                lost    <= 1'b1;
              end else begin
                r_state     <= ST_FLY;
                r_misses    <= MISS_W'(1);
                frame_start <= 1'b1;
              end
            end
          end
          ST_FLY: begin
            if (w_ckpt) begin
              if (w_hit) begin
                r_state     <= ST_LOCK;
                r_misses    <= '0;
                frame_start <= 1'b1;
              end else if (r_misses == MISS_W'(MISS_CNT - 1)) begin
                r_state <= ST_HUNT;
                locked  <= 1'b0;
                lost    <= 1'b1;
              end else begin
                r_misses    <= r_misses + MISS_W'(1);
                frame_start <= 1'b1;
              end
            end
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_frame_sync_ctrl.sv
// Randomized bench for seq_frame_sync_ctrl against a bit-index based reference model.
module tb_seq_frame_sync_ctrl;

  localparam int unsigned PAT_W    = 5;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned LOCK_CNT = 3;
  localparam int unsigned MISS_CNT = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic             in_bit;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_flen;
  logic             match;
  logic             locked;
  logic             frame_start;
  logic             lost;
  logic [1:0]       sync_state;
  logic [15:0]      match_count;

  always #5 clk = ~clk;

  seq_frame_sync_ctrl #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .MISS_CNT(MISS_CNT)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .en(en), .in(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_flen(cfg_flen), .match(match), .locked(locked),
    .frame_start(frame_start), .lost(lost), .sync_state(sync_state),
    .match_count(match_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  int g_gap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: checkpoints are absolute accepted-bit indices.
  int m_pat, m_flen, m_n, m_next_cp, m_state, m_hits, m_misses, m_count;
  int m_hist[$];
  bit m_match, m_fs, m_lost;

  task automatic model_reset();
    m_pat = 5'b11011; m_flen = 16; m_n = 0; m_next_cp = 0; m_state = 0;
    m_hits = 0; m_misses = 0; m_count = 0; m_hist.delete();
    m_match = 0; m_fs = 0; m_lost = 0;
  endtask

  task automatic model_step(input logic e, input logic b, input logic ld,
                            input int pat, input int fl);
    bit hit;
    int w;
    m_match = 0; m_fs = 0; m_lost = 0;
    if (ld) begin
      m_pat = pat; m_flen = (fl < PAT_W) ? PAT_W : fl;
      m_hist.delete(); m_n = 0; m_count = 0; m_state = 0;
    end else if (e) begin
      m_hist.push_back(int'(b));
      if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
      w = 0;
      foreach (m_hist[i]) w = w * 2 + m_hist[i];
      hit = (m_hist.size() == PAT_W) && (w == m_pat);
      m_n++;
      m_match = hit;
      if (hit && m_count < 65535) m_count++;
      if (m_state == 0) begin
        if (hit) begin m_state = 1; m_hits = 1; m_next_cp = m_n + m_flen; end
      end else if (m_n == m_next_cp) begin
        m_next_cp += m_flen;
        case (m_state)
          1: if (hit) begin
               m_hits++;
               if (m_hits >= LOCK_CNT) begin m_state = 2; m_fs = 1; end
             end else m_state = 0;
          2: if (hit) m_fs = 1;
             else begin
               m_misses = 1;
               if (m_misses >= MISS_CNT) begin m_state = 0; m_lost = 1; end
               else begin m_state = 3; m_fs = 1; end
             end
          default: if (hit) begin m_state = 2; m_fs = 1; end
             else begin
               m_misses++;
               if (m_misses >= MISS_CNT) begin m_state = 0; m_lost = 1; end
               else m_fs = 1;
             end
        endcase
      end
    end
  endtask

  task automatic compare_all();
    check("match", match, m_match);
    check("frame_start", frame_start, m_fs);
    check("lost", lost, m_lost);
    check("locked", locked, (m_state >= 2));
    check("sync_state", sync_state, m_state);
    check("match_count", match_count, m_count);
  endtask

  task automatic cyc(input logic e, input logic b, input logic ld = 1'b0,
                     input logic [PAT_W-1:0] pat = '0, input logic [CNT_W-1:0] fl = '0);
    @(negedge clk);
    en = e; cfg_load = ld;
    in_bit = e ? b : 1'($urandom);
    cfg_pattern = ld ? pat : PAT_W'($urandom);
    cfg_flen    = ld ? fl  : CNT_W'($urandom);
    model_step(e, in_bit, ld, int'(pat), int'(fl));
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic send_bit(input logic b);
    for (int k = 0; k < 4 && ($urandom_range(0, 99) < g_gap); k++) cyc(1'b0, 1'b0);
    cyc(1'b1, b);
  endtask

  task automatic send_word(input logic [PAT_W-1:0] w);
    for (int i = PAT_W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  // Payload of (flen - PAT_W) bits followed by a sync word (good or corrupted).
  task automatic send_frame(input bit good, input bit rnd_payload);
    logic [PAT_W-1:0] s;
    for (int i = 0; i < m_flen - PAT_W; i++) send_bit(rnd_payload ? 1'($urandom) : 1'b0);
    s = PAT_W'(m_pat);
    send_word(good ? s : (s ^ PAT_W'(5'b00100)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; cfg_load = 1'b0; reset_n = 1'b0;
    #1;
    check("rst_match", match, 0);
    check("rst_locked", locked, 0);
    check("rst_fs", frame_start, 0);
    check("rst_lost", lost, 0);
    check("rst_state", sync_state, 0);
    check("rst_count", match_count, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int cnt_before;
  logic [7:0] ovl_bits;
  logic [10:0] spur;

  initial begin
    reset_n = 1'b0; en = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_flen = '0;
    model_reset();
    do_reset();

    // Overlapping detection
    ovl_bits = 8'b11011011;
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b1, ovl_bits[i]);
      if (i == 3 || i == 0) check("ovl_match", match, 1);
    end
    check("ovl_count", match_count, 2);

    // Acquire with default cfg, then flywheel and loss
    do_reset();
    send_word(5'b11011);
    check("acq_verify", sync_state, 1);
    send_frame(1'b1, 1'b0);
    check("acq_still_verify", sync_state, 1);
    send_frame(1'b1, 1'b0);
    check("acq_lock", sync_state, 2);
    check("acq_locked", locked, 1);
    check("acq_fs", frame_start, 1);
    send_frame(1'b0, 1'b0);
    check("fly_state", sync_state, 3);
    check("fly_locked", locked, 1);
    check("fly_fs", frame_start, 1);
    send_frame(1'b1, 1'b0);
    check("fly_relock", sync_state, 2);
    send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);
    check("loss_lost", lost, 1);
    check("loss_locked", locked, 0);
    check("loss_state", sync_state, 0);

    // Spurious sync mid-frame while locked
    send_word(5'b11011);
    send_frame(1'b1, 1'b0);
    send_frame(1'b1, 1'b0);
    cnt_before = int'(match_count);
    spur = 11'b00011011000;
    for (int i = 10; i >= 0; i--) begin
      send_bit(spur[i]);
      if (i == 3) check("spur_match", match, 1);
    end
    check("spur_count", match_count, 32'(cnt_before + 1));
    check("spur_state", sync_state, 2);
    send_word(5'b11011);
    check("spur_fs", frame_start, 1);

    // cfg_load while verifying, with en high in the same cycle
    do_reset();
    send_word(5'b11011);
    check("cfg_pre_verify", sync_state, 1);
    cyc(1'b1, 1'b1, 1'b1, 5'b10101, 8'd8);
    check("cfg_hunt", sync_state, 0);
    check("cfg_count", match_count, 0);
    send_word(5'b11011);
    check("cfg_old_pat", match_count, 0);
    send_word(5'b10101);
    check("cfg_new_pat", sync_state, 1);
    send_frame(1'b1, 1'b0);
    send_frame(1'b1, 1'b0);
    check("cfg_lock", sync_state, 2);

    // Randomized traffic with gaps, corrupted syncs, reconfiguration and resets
    g_gap = 25;
    for (int it = 0; it < 40; it++) begin
      if (it == 20) do_reset();
      else if ($urandom_range(0, 2) != 0)
        cyc(1'($urandom), 1'($urandom), 1'b1, PAT_W'($urandom), CNT_W'($urandom_range(0, 20)));
      send_word(PAT_W'(m_pat));
      for (int f = 0; f < int'($urandom_range(4, 10)); f++)
        send_frame($urandom_range(0, 99) < 75, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
